pe_acc_drain: RTL and testbench
===============================

# pe_acc_drain

Downstream drain stage for the 2x2 systolic PE wrapper. It pops 4-lane result words from the PE output FIFO, accumulates `k_len` consecutive words per lane into saturating accumulators to form one 2x2 C tile, and presents the finished tile on a valid/ready stream. Back-pressure from the tile consumer stalls popping, so the PE output FIFO absorbs the stall.

## Interface
Parameters:
- `WIDTH`, default 4: PE operand width. Each PE result lane is 2*WIDTH+1 bits, unsigned.
- `MAX_K`, default 16: maximum number of words accumulated per tile.
- `ACC_W`, default 12: accumulator and output lane width. Must satisfy ACC_W >= 2*WIDTH+1.
- `KW`, derived as $clog2(MAX_K+1): width of `k_len`.

Ports:
- `clk`, input, 1: single clock; all state is rising-edge.
- `rst_n`, input, 1: reset, asynchronous and active-low. Clears all state immediately.
- `k_len`, input, KW: words per tile. Sampled only on the first pop of a tile. A value of 0 is treated as 1; values above MAX_K are clamped to MAX_K.
- `pe_cout`, input, [3:0][2*WIDTH:0]: head word of the PE output FIFO. This is a show-ahead FIFO. Lane map: 0=c00, 1=c01, 2=c10, 3=c11.
- `pe_cout_val`, input, 1: the head word is valid.
- `pe_pop`, output, 1: consumes the head word in this cycle.
- `tile`, output, [3:0][ACC_W-1:0]: the accumulated tile.
- `tile_val`, output, 1: `tile` is valid.
- `tile_rdy`, input, 1: the consumer accepts the tile.
- `tile_ovf`, output, 1: at least one lane of the current tile saturated. Meaningful only while `tile_val` is high.
- `tile_cnt`, output, 16: number of tiles delivered. Wraps from 0xFFFF to 0.
- `busy`, output, 1: a tile is in progress or being held.

## Operation
- The state machine has three states: IDLE, ACCUM, DONE.
- **IDLE.** When `pe_cout_val` is high:
  - Pop one word and load each accumulator with its lane, zero-extended.
  - Latch the effective k (after the 0 and clamp rules) and set `cnt` to 1.
  - Clear the overflow sticky.
  - Go to DONE if k==1, otherwise go to ACCUM.
- **ACCUM.** When `pe_cout_val` is high:
  - Pop one word, set acc += lane for every lane, and increment `cnt`.
  - When the incremented `cnt` equals k, go to DONE.
  - With no valid word, hold all state.
- **DONE.**
  - `tile_val` is high, and `tile` is driven directly from the accumulator registers, stable until the handshake.
  - On `tile_rdy`: increment `tile_cnt`.
  - If `pe_cout_val` is also high in that cycle, pop and start the next tile exactly as IDLE does (zero-bubble). Otherwise go to IDLE.
  - Without `tile_rdy`, hold and never pop.
- **`pe_pop`** is combinational: `pe_cout_val` AND (IDLE, or ACCUM, or (DONE and `tile_rdy`)). It is never asserted while `pe_cout_val` is low.
- **Saturation.** Each lane's sum is computed at ACC_W+1 bits. If the result exceeds 2^ACC_W-1, the lane is clamped to 2^ACC_W-1 and the sticky `tile_ovf` is set. The sticky stays set until the next tile's first pop.
- **`busy`** = (state != IDLE).

## Timing
- Reset values:
  - state: IDLE.
  - `tile`: 0. `tile_val`: 0. `tile_ovf`: 0. `tile_cnt`: 0. `busy`: 0.
  - `pe_pop`: 0, because it is gated while `rst_n` is low.
- Latency: `tile_val` rises in the cycle after the pop of the k-th word.
- Throughput: one word per cycle. With `tile_rdy` held high, k words produce a tile every k cycles with no gap.
- Reset mid-tile: the partial sums are discarded. After `rst_n` is released, the first valid word starts a fresh tile.
- Accepting a tile and popping the first word of the next tile in the same cycle is legal. In that cycle `tile` still shows the old tile; the new values appear on the following edge.

## Structure
- The shared package `pe_pkg` holds the `drain_state_t` enum (IDLE, ACCUM, DONE) and the lane-count constant `PE_LANES`=4.
- Sub-module `pe_acc_lane`, instantiated 4x: one saturating accumulator with load, add and ovf outputs.
- The state machine, `cnt`, the k latch and `tile_cnt` live in `pe_acc_drain`.

## Test plan
All scenarios use WIDTH=4, MAX_K=16, ACC_W=12.
- **Single-word tile.** k_len=1, one word {1,2,3,4} → `pe_pop` for 1 cycle; next cycle `tile`={1,2,3,4}, `tile_val`=1, `tile_ovf`=0; after `tile_rdy`, `tile_cnt`=1.
- **Multi-word with gaps.** k_len=3, words {1,1,1,1}, {2,2,2,2}, {3,3,3,3} with 2-cycle valid gaps → `tile`={6,6,6,6}; exactly 3 pops.
- **Back-pressure and zero-bubble restart.**
  - Setup: tile ready, `tile_rdy`=0 for 5 cycles, `pe_cout_val`=1.
  - During the stall: `pe_pop`=0 and `tile` stable.
  - When `tile_rdy`=1: `pe_pop`=1 in the same cycle; the next tile starts with no idle cycle.
- **Saturation.** k_len=16, lane0=300 and lanes 1-3=10 in every word → `tile`={4095,160,160,160}, `tile_ovf`=1. The next clean tile has `tile_ovf`=0.
- **k_len boundaries.**
  - k_len=0 → tile after 1 word.
  - k_len=20 → tile after 16 words.
  - k_len changed mid-tile → no effect on the current tile.
- **Reset mid-tile.** k_len=4, drop `rst_n` after 2 pops → `busy`/`tile_val`/`pe_pop` go to 0 immediately. After release, 4 words of {5,5,5,5} → `tile`={20,20,20,20}, `tile_cnt`=1.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and constants for the systolic PE wrapper and its drain stage.
package pe_pkg;
    localparam int unsigned PE_LANES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } drain_state_t;
endpackage

// File: rtl/pe_acc_drain_if.sv
// Drain-stage streams: PE output FIFO head word in, accumulated C tile out.
interface pe_acc_drain_if
    import pe_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned ACC_W = 12
);
    logic [PE_LANES-1:0][2*WIDTH:0] pe_cout;
    logic                           pe_cout_val;
    logic                           pe_pop;
    logic [PE_LANES-1:0][ACC_W-1:0] tile;
    logic                           tile_val;
    logic                           tile_rdy;
    logic                           tile_ovf;

    modport master (
        output pe_cout, pe_cout_val, tile_rdy,
        input  pe_pop, tile, tile_val, tile_ovf
    );

    modport slave (
        input  pe_cout, pe_cout_val, tile_rdy,
        output pe_pop, tile, tile_val, tile_ovf
    );
endinterface

// File: rtl/pe_acc_lane.sv
// One saturating accumulator lane: load zero-extends, add clamps at all-ones.
module pe_acc_lane #(
    parameter int unsigned IN_W  = 9,
    parameter int unsigned ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             add,
    input  logic [IN_W-1:0]  din,
    output logic [ACC_W-1:0] acc,
    output logic             sat_c
);
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    logic [ACC_W:0] sum_c;

    // One extra bit catches any sum past the accumulator range.
    assign sum_c = {1'b0, acc} + (ACC_W+1)'(din);
    assign sat_c = add & sum_c[ACC_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (load) begin
            acc <= ACC_W'(din);
        end else if (add) begin
            acc <= sum_c[ACC_W] ? ACC_MAX : sum_c[ACC_W-1:0];
        end
    end
endmodule

// File: rtl/pe_acc_drain.sv
// Pops PE result words, sums k_len of them per lane into one 2x2 C tile.
module pe_acc_drain
    import pe_pkg::*;
#(
    parameter  int unsigned WIDTH = 4,
    parameter  int unsigned MAX_K = 16,
    parameter  int unsigned ACC_W = 12,
    localparam int unsigned KW    = $clog2(MAX_K + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [KW-1:0]     k_len,
    pe_acc_drain_if.slave     bus,
    output logic [15:0]       tile_cnt,
    output logic              busy
);
    localparam int unsigned   LANE_W = 2 * WIDTH + 1;
    localparam logic [KW-1:0] K_MAX  = KW'(MAX_K);
    localparam logic [KW-1:0] K_ONE  = KW'(1);

    drain_state_t        state;
    logic [KW-1:0]       k_q;
    logic [KW-1:0]       cnt;
    logic [KW-1:0]       k_eff_c;
    logic [PE_LANES-1:0] sat_c;
    logic                start_c;
    logic                add_c;
    logic                accept_c;

    // Pop is gated by reset so nothing is consumed while the stage is cleared.
    assign bus.pe_pop = rst_n & bus.pe_cout_val & ((state != DONE) | bus.tile_rdy);
    assign start_c    = bus.pe_pop & (state != ACCUM);
    assign add_c      = bus.pe_pop & (state == ACCUM);
    assign accept_c   = (state == DONE) & bus.tile_rdy;

    always_comb begin
        k_eff_c = k_len;
        if (k_len == '0) begin
            k_eff_c = K_ONE;
        end else if (k_len > K_MAX) begin
            k_eff_c = K_MAX;
        end
    end

    for (genvar l = 0; l < PE_LANES; l++) begin : g_lane
        pe_acc_lane #(
            .IN_W  (LANE_W),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (start_c),
            .add   (add_c),
            .din   (bus.pe_cout[l]),
            .acc   (bus.tile[l]),
            .sat_c (sat_c[l])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            k_q          <= '0;
            cnt          <= '0;
            tile_cnt     <= '0;
            bus.tile_ovf <= 1'b0;
            bus.tile_val <= 1'b0;
            busy         <= 1'b0;
        end else begin
            if (start_c) begin
                bus.tile_ovf <= 1'b0;
            end else if (add_c && (sat_c != '0)) begin
                bus.tile_ovf <= 1'b1;
            end

            if (accept_c) begin
                tile_cnt <= tile_cnt + 16'd1;
            end

            unique case (state)
                IDLE, DONE: begin
                    if (start_c) begin
                        k_q  <= k_eff_c;
                        cnt  <= K_ONE;
                        busy <= 1'b1;
                        if (k_eff_c == K_ONE) begin
                            state        <= DONE;
                            bus.tile_val <= 1'b1;
                        end else begin
                            state        <= ACCUM;
                            bus.tile_val <= 1'b0;
                        end
                    end else if (accept_c) begin
                        state        <= IDLE;
                        bus.tile_val <= 1'b0;
                        busy         <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (add_c) begin
                        cnt <= cnt + K_ONE;
                        if ((cnt + K_ONE) == k_q) begin
                            state        <= DONE;
                            bus.tile_val <= 1'b1;
                        end
                    end
                end
                default: begin
                    state        <= IDLE;
                    bus.tile_val <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pe_acc_drain.sv
// Randomized bench for pe_acc_drain against a per-tile sum-and-clamp model.
module tb_pe_acc_drain;
    import pe_pkg::*;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned MAX_K = 16;
    localparam int unsigned ACC_W = 12;
    localparam int unsigned KW    = $clog2(MAX_K + 1);
    localparam int          SAT   = (1 << ACC_W) - 1;

    typedef logic [PE_LANES-1:0][2*WIDTH:0] word_t;
    typedef logic [PE_LANES-1:0][ACC_W-1:0] tile_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [KW-1:0] k_len = '0;
    logic [15:0]   tile_cnt;
    logic          busy;

    pe_acc_drain_if #(.WIDTH(WIDTH), .ACC_W(ACC_W)) bus ();

    pe_acc_drain #(.WIDTH(WIDTH), .MAX_K(MAX_K), .ACC_W(ACC_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .k_len    (k_len),
        .bus      (bus.slave),
        .tile_cnt (tile_cnt),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int pops  = 0;
    int cyc   = 0;
    int m_sum [PE_LANES];
    int exp_cnt = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && bus.pe_pop) pops <= pops + 1;
    end

    function automatic void clear_model();
        for (int l = 0; l < PE_LANES; l++) m_sum[l] = 0;
    endfunction

    function automatic tile_t model_tile();
        tile_t t;
        for (int l = 0; l < PE_LANES; l++)
            t[l] = ACC_W'((m_sum[l] > SAT) ? SAT : m_sum[l]);
        return t;
    endfunction

    function automatic logic model_ovf();
        logic o = 1'b0;
        for (int l = 0; l < PE_LANES; l++) if (m_sum[l] > SAT) o = 1'b1;
        return o;
    endfunction

    function automatic int eff_k(input int k);
        return (k == 0) ? 1 : ((k > int'(MAX_K)) ? int'(MAX_K) : k);
    endfunction

    function automatic word_t rand_word(input int hi);
        word_t w;
        for (int l = 0; l < PE_LANES; l++) w[l] = (2*WIDTH+1)'($urandom_range(hi, 0));
        return w;
    endfunction

    // Present one word starting at a negedge until it is popped; ends at a negedge.
    task automatic feed(input word_t w);
        bit ok = 1'b0;
        bus.pe_cout     = w;
        bus.pe_cout_val = 1'b1;
        for (int n = 0; n < 64 && !ok; n++) begin
            #1 ok = bus.pe_pop;
            @(posedge clk);
            if (!ok) @(negedge clk);
        end
        @(negedge clk);
        bus.pe_cout_val = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL feed_timeout got=no_pop exp=pop");
        end else begin
            for (int l = 0; l < PE_LANES; l++) m_sum[l] += int'(w[l]);
        end
    endtask

    // Hand the finished tile to the consumer for one cycle.
    task automatic accept();
        bus.tile_rdy = 1'b1;
        @(negedge clk);
        bus.tile_rdy = 1'b0;
        exp_cnt++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.pe_cout     = rand_word(511);
        bus.pe_cout_val = 1'b1;
        bus.tile_rdy    = 1'b0;
        k_len = KW'(1);
        repeat (2) @(negedge clk);
        #1;
        total += 6;
        if (bus.pe_pop !== 1'b0)   begin bad++; $display("FAIL rst_pop got=%b exp=0", bus.pe_pop); end
        if (bus.tile_val !== 1'b0) begin bad++; $display("FAIL rst_tile_val got=%b exp=0", bus.tile_val); end
        if (busy !== 1'b0)         begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        if (bus.tile_ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", bus.tile_ovf); end
        if (tile_cnt !== 16'd0)    begin bad++; $display("FAIL rst_cnt got=%0d exp=0", tile_cnt); end
        if (bus.tile !== '0)       begin bad++; $display("FAIL rst_tile got=%h exp=0", bus.tile); end
        bus.pe_cout_val = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        word_t w;
        int p0;
        tile_t exp_t;
        for (int l = 0; l < PE_LANES; l++) w[l] = (2*WIDTH+1)'(l + 1);
        clear_model();
        k_len = KW'(1);
        p0 = pops;
        feed(w);
        #1;
        exp_t = model_tile();
        total += 4;
        if (bus.tile_val !== 1'b1) begin bad++; $display("FAIL single_val got=%b exp=1", bus.tile_val); end
        if (bus.tile !== exp_t)    begin bad++; $display("FAIL single_tile got=%h exp=%h", bus.tile, exp_t); end
        if (bus.tile_ovf !== 1'b0) begin bad++; $display("FAIL single_ovf got=%b exp=0", bus.tile_ovf); end
        if (pops - p0 != 1)        begin bad++; $display("FAIL single_pops got=%0d exp=1", pops - p0); end
        accept();
        #1;
        total += 2;
        if (tile_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL single_cnt got=%0d exp=%0d", tile_cnt, exp_cnt); end
        if (busy !== 1'b0)             begin bad++; $display("FAIL single_idle got=%b exp=0", busy); end
    endtask

    task automatic test_gaps();
        word_t w;
        int p0;
        tile_t exp_t;
        clear_model();
        k_len = KW'(3);
        p0 = pops;
        for (int i = 1; i <= 3; i++) begin
            for (int l = 0; l < PE_LANES; l++) w[l] = (2*WIDTH+1)'(i);
            feed(w);
            #1;
            total++;
            if (bus.tile_val !== (i == 3)) begin bad++; $display("FAIL gaps_val%0d got=%b exp=%b", i, bus.tile_val, i == 3); end
            if (i < 3) repeat (2) @(negedge clk);
        end
        exp_t = model_tile();
        total += 2;
        if (bus.tile !== exp_t) begin bad++; $display("FAIL gaps_tile got=%h exp=%h", bus.tile, exp_t); end
        if (pops - p0 != 3)     begin bad++; $display("FAIL gaps_pops got=%0d exp=3", pops - p0); end
        accept();
        #1;
        total++;
        if (tile_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL gaps_cnt got=%0d exp=%0d", tile_cnt, exp_cnt); end
    endtask

    task automatic test_backpressure();
        word_t w;
        tile_t exp_t;
        clear_model();
        k_len = KW'(2);
        feed(rand_word(511));
        feed(rand_word(511));
        exp_t = model_tile();
        w = rand_word(511);
        bus.pe_cout     = w;
        bus.pe_cout_val = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            total += 3;
            if (bus.pe_pop !== 1'b0)   begin bad++; $display("FAIL bp_pop%0d got=%b exp=0", i, bus.pe_pop); end
            if (bus.tile_val !== 1'b1) begin bad++; $display("FAIL bp_val%0d got=%b exp=1", i, bus.tile_val); end
            if (bus.tile !== exp_t)    begin bad++; $display("FAIL bp_tile%0d got=%h exp=%h", i, bus.tile, exp_t); end
            @(negedge clk);
        end
        bus.tile_rdy = 1'b1;
        #1;
        total += 2;
        if (bus.pe_pop !== 1'b1) begin bad++; $display("FAIL bp_restart_pop got=%b exp=1", bus.pe_pop); end
        if (bus.tile !== exp_t)  begin bad++; $display("FAIL bp_old_tile got=%h exp=%h", bus.tile, exp_t); end
        @(negedge clk);
        bus.tile_rdy    = 1'b0;
        bus.pe_cout_val = 1'b0;
        exp_cnt++;
        clear_model();
        for (int l = 0; l < PE_LANES; l++) m_sum[l] = int'(w[l]);
        #1;
        total += 3;
        if (busy !== 1'b1)             begin bad++; $display("FAIL bp_busy got=%b exp=1", busy); end
        if (bus.tile_val !== 1'b0)     begin bad++; $display("FAIL bp_newval got=%b exp=0", bus.tile_val); end
        if (tile_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL bp_cnt got=%0d exp=%0d", tile_cnt, exp_cnt); end
        feed(rand_word(511));
        exp_t = model_tile();
        #1;
        total++;
        if (bus.tile !== exp_t) begin bad++; $display("FAIL bp_second got=%h exp=%h", bus.tile, exp_t); end
        accept();
    endtask

    task automatic test_back_to_back();
        int p0, c0;
        tile_t exp_t;
        k_len = KW'(3);
        bus.tile_rdy = 1'b1;
        p0 = pops;
        c0 = cyc;
        for (int t = 0; t < 3; t++) begin
            clear_model();
            for (int i = 0; i < 3; i++) feed(rand_word(511));
            exp_t = model_tile();
            #1;
            total += 2;
            if (bus.tile_val !== 1'b1) begin bad++; $display("FAIL b2b_val%0d got=%b exp=1", t, bus.tile_val); end
            if (bus.tile !== exp_t)    begin bad++; $display("FAIL b2b_tile%0d got=%h exp=%h", t, bus.tile, exp_t); end
        end
        total += 2;
        if (pops - p0 != 9) begin bad++; $display("FAIL b2b_pops got=%0d exp=9", pops - p0); end
        if (cyc - c0 != 9)  begin bad++; $display("FAIL b2b_cycles got=%0d exp=9", cyc - c0); end
        @(negedge clk);
        bus.tile_rdy = 1'b0;
        exp_cnt += 3;
        #1;
        total++;
        if (tile_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL b2b_cnt got=%0d exp=%0d", tile_cnt, exp_cnt); end
    endtask

    task automatic test_saturation();
        word_t w;
        tile_t exp_t;
        w[0] = 9'd300;
        for (int l = 1; l < PE_LANES; l++) w[l] = 9'd10;
        clear_model();
        k_len = KW'(16);
        for (int i = 0; i < 16; i++) feed(w);
        exp_t = model_tile();
        #1;
        total += 3;
        if (bus.tile !== {12'd160, 12'd160, 12'd160, 12'd4095})
            begin bad++; $display("FAIL sat_tile got=%h exp=0a00a00a0fff", bus.tile); end
        if (bus.tile !== exp_t)    begin bad++; $display("FAIL sat_model got=%h exp=%h", bus.tile, exp_t); end
        if (bus.tile_ovf !== 1'b1) begin bad++; $display("FAIL sat_ovf got=%b exp=1", bus.tile_ovf); end
        accept();
        clear_model();
        k_len = KW'(2);
        feed(rand_word(511));
        feed(rand_word(511));
        #1;
        total++;
        if (bus.tile_ovf !== 1'b0) begin bad++; $display("FAIL sat_clear got=%b exp=0", bus.tile_ovf); end
        accept();
    endtask

    task automatic test_k_bounds();
        int kk;
        int n;
        tile_t exp_t;
        for (int t = 0; t < 6; t++) begin
            kk = (t == 0) ? 0 : (t == 1) ? 20 : (t == 2) ? 3 : $urandom_range(20, 0);
            n  = eff_k(kk);
            clear_model();
            k_len = KW'(kk);
            for (int i = 0; i < n; i++) begin
                feed(rand_word((t == 5) ? 511 : 40));
                if (t == 2) k_len = KW'(1 + 4 * i);
                #1;
                total++;
                if (bus.tile_val !== (i == n - 1))
                    begin bad++; $display("FAIL kb_val k=%0d w=%0d got=%b exp=%b", kk, i, bus.tile_val, i == n - 1); end
            end
            exp_t = model_tile();
            total += 2;
            if (bus.tile !== exp_t)         begin bad++; $display("FAIL kb_tile k=%0d got=%h exp=%h", kk, bus.tile, exp_t); end
            if (bus.tile_ovf !== model_ovf()) begin bad++; $display("FAIL kb_ovf k=%0d got=%b exp=%b", kk, bus.tile_ovf, model_ovf()); end
            accept();
            if ($urandom_range(1, 0) == 1) repeat ($urandom_range(3, 1)) @(negedge clk);
        end
        #1;
        total++;
        if (tile_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL kb_cnt got=%0d exp=%0d", tile_cnt, exp_cnt); end
    endtask

    task automatic test_reset_mid();
        word_t w;
        tile_t exp_t;
        k_len = KW'(4);
        feed(rand_word(511));
        feed(rand_word(511));
        bus.pe_cout     = rand_word(511);
        bus.pe_cout_val = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        total += 3;
        if (busy !== 1'b0)         begin bad++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        if (bus.tile_val !== 1'b0) begin bad++; $display("FAIL rmid_val got=%b exp=0", bus.tile_val); end
        if (bus.pe_pop !== 1'b0)   begin bad++; $display("FAIL rmid_pop got=%b exp=0", bus.pe_pop); end
        @(negedge clk);
        bus.pe_cout_val = 1'b0;
        rst_n = 1'b1;
        exp_cnt = 0;
        @(negedge clk);
        clear_model();
        for (int l = 0; l < PE_LANES; l++) w[l] = 9'd5;
        for (int i = 0; i < 4; i++) feed(w);
        exp_t = model_tile();
        #1;
        total += 2;
        if (bus.tile !== exp_t)    begin bad++; $display("FAIL rmid_tile got=%h exp=%h", bus.tile, exp_t); end
        if (bus.tile_val !== 1'b1) begin bad++; $display("FAIL rmid_done got=%b exp=1", bus.tile_val); end
        accept();
        #1;
        total++;
        if (tile_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL rmid_cnt got=%0d exp=%0d", tile_cnt, exp_cnt); end
    endtask

    initial begin
        bus.pe_cout     = '0;
        bus.pe_cout_val = 1'b0;
        bus.tile_rdy    = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_gaps();
        test_backpressure();
        test_back_to_back();
        test_saturation();
        test_k_bounds();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
